// File: rtl/mem_array.sv
// mem_array: single-port, word-addressed synchronous memory slave.
// One read or write is accepted per rising edge where valid && ready.
// Writes update the array; reads return registered data on rdata.
// The array, rdata and ready are all cleared by an asynchronous active-low reset.

module mem_array #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   input  logic                  wr_rd,
   input  logic                  valid,
   output logic                  ready
);

   // Handshake: a request transfers on a rising edge where valid and ready
   // are both 1. ready is a flop that is 0 during reset, rises on the first
   // edge after release and then stays high, so the slave never stalls the
   // master outside reset. The master keeps addr/wdata/wr_rd stable while
   // valid is high and ready is low. A valid that is not a clean 1 (X/Z)
   // never transfers because the qualifying if-condition is not true.

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rdata_d;
   logic                  ready_q;
   logic                  ready_d;
   logic                  accept;
   logic                  do_write;
   logic                  do_read;

   assign accept   = valid & ready_q;
   assign do_write = accept & wr_rd;
   assign do_read  = accept & ~wr_rd;

   // Next-state for the ready flop: leaving reset always means able to accept.
   always_comb begin
      ready_d = 1'b1;
   end

   // Next-state for rdata: load the pre-edge array word on an accepted read,
   // otherwise hold the last returned word.
   always_comb begin
      rdata_d = rdata_q;
      if (do_read) begin
         rdata_d = mem_q[addr];
      end
   end

   // ready register: 0 in reset, set on the first edge after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= ready_d;
      end
   end

   // Read data register: cleared in reset, updated only by accepted reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   // Storage array: every word cleared in reset; one word written per
   // accepted write. Reads in the same edge see the old contents because the
   // read path samples mem_q before this update lands.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_write) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = rdata_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_mem_array.sv
// tb_mem_array: directed and scoreboard-checked bench for mem_array.

module tb_mem_array;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          wr_rd;
   logic          valid;
   logic          ready;

   int errors;
   int checks;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] model [256];

   mem_array #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .DEPTH     (256)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .addr (addr),
      .wdata(wdata),
      .rdata(rdata),
      .wr_rd(wr_rd),
      .valid(valid),
      .ready(ready)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- driver tasks ----------------
   // Present one request, let the next edge accept it, return 1 time unit after.
   task automatic req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      valid = 1'b1;
      wr_rd = wr;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst   = 1'b0;
      valid = 1'b0;
      wr_rd = 1'b0;
      addr  = '0;
      wdata = '0;
      @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h0) begin
         errors++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0);
      end
      checks++;
      if (ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b want 0", ready);
      end
      // Release with a write already presented: the first edge must not take it.
      rst   = 1'b1;
      valid = 1'b1;
      wr_rd = 1'b1;
      addr  = 8'h05;
      wdata = 32'hFFFF_0000;
      #1;
      checks++;
      if (ready !== 1'b0) begin
         errors++; $display("FAIL ready_before_edge: got %b want 0", ready);
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
      checks++;
      if (ready !== 1'b1) begin
         errors++; $display("FAIL ready_after_release: got %b want 1", ready);
      end
      req(1'b0, 8'h05, '0);
      valid = 1'b0;
      checks++;
      if (rdata !== 32'h0) begin
         errors++; $display("FAIL read_0x05_after_reset: got %h want %h", rdata, 32'h0);
      end
   endtask

   task automatic test_write_read();
      req(1'b1, 8'h10, 32'hDEAD_BEEF);
      checks++;
      if (rdata !== 32'h0) begin
         errors++; $display("FAIL write_keeps_rdata: got %h want %h", rdata, 32'h0);
      end
      req(1'b0, 8'h10, '0);
      valid = 1'b0;
      checks++;
      if (rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL write_read_0x10: got %h want %h", rdata, 32'hDEAD_BEEF);
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] ra [3];
      logic [DW-1:0] rexp [3];
      ra[0] = 8'hFF; ra[1] = 8'h00; ra[2] = 8'h01;
      rexp[0] = 32'h3333_3333; rexp[1] = 32'h1111_1111; rexp[2] = 32'h2222_2222;
      req(1'b1, 8'h00, 32'h1111_1111);
      req(1'b1, 8'h01, 32'h2222_2222);
      req(1'b1, 8'hFF, 32'h3333_3333);
      for (int i = 0; i < 3; i++) begin
         req(1'b0, ra[i], '0);
         checks++;
         if (rdata !== rexp[i]) begin
            errors++; $display("FAIL b2b_read_%0d addr %h: got %h want %h", i, ra[i], rdata, rexp[i]);
         end
      end
      // Read right after a write to the same address sees the new word.
      req(1'b1, 8'h30, 32'h0BAD_F00D);
      req(1'b0, 8'h30, '0);
      valid = 1'b0;
      checks++;
      if (rdata !== 32'h0BAD_F00D) begin
         errors++; $display("FAIL raw_same_addr: got %h want %h", rdata, 32'h0BAD_F00D);
      end
   endtask

   task automatic test_idle_valid();
      req(1'b0, 8'h10, '0);
      valid = 1'b0;
      wr_rd = 1'b1;
      addr  = 8'h20;
      wdata = 32'hAAAA_5555;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL idle_hold_%0d: got %h want %h", i, rdata, 32'hDEAD_BEEF);
         end
      end
      req(1'b0, 8'h20, '0);
      valid = 1'b0;
      checks++;
      if (rdata !== 32'h0) begin
         errors++; $display("FAIL idle_no_write_0x20: got %h want %h", rdata, 32'h0);
      end
   endtask

   task automatic test_reset_mid();
      req(1'b1, 8'h40, 32'h1234_5678);
      req(1'b0, 8'h40, '0);
      valid = 1'b0;
      checks++;
      if (rdata !== 32'h1234_5678) begin
         errors++; $display("FAIL pre_reset_read_0x40: got %h want %h", rdata, 32'h1234_5678);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (rdata !== 32'h0) begin
         errors++; $display("FAIL async_reset_rdata: got %h want %h", rdata, 32'h0);
      end
      checks++;
      if (ready !== 1'b0) begin
         errors++; $display("FAIL async_reset_ready: got %b want 0", ready);
      end
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1) begin
         errors++; $display("FAIL ready_after_mid_reset: got %b want 1", ready);
      end
      req(1'b0, 8'h40, '0);
      checks++;
      if (rdata !== 32'h0) begin
         errors++; $display("FAIL post_reset_read_0x40: got %h want %h", rdata, 32'h0);
      end
      req(1'b0, 8'h10, '0);
      valid = 1'b0;
      checks++;
      if (rdata !== 32'h0) begin
         errors++; $display("FAIL post_reset_read_0x10: got %h want %h", rdata, 32'h0);
      end
   endtask

   // Random sweep against a bench-side word model (array is zero after reset).
   task automatic test_random();
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] exp;
      logic [DW-1:0] last;
      for (int i = 0; i < 256; i++) model[i] = '0;
      last = '0;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            idle(1);
            checks++;
            if (rdata !== last) begin
               errors++; $display("FAIL rand_hold_%0d: got %h want %h", n, rdata, last);
            end
         end
         wr = 1'($urandom_range(0, 1));
         a  = 8'($urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(0, 255));
         d  = $urandom;
         if (!wr) exp_q.push_back(model[a]);
         req(wr, a, d);
         if (wr) begin
            model[a] = d;
         end else begin
            exp = exp_q.pop_front();
            last = exp;
            checks++;
            if (rdata !== exp) begin
               errors++; $display("FAIL rand_read_%0d addr %h: got %h want %h", n, a, rdata, exp);
            end
         end
      end
      valid = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_idle_valid();
      test_reset_mid();
      test_random();
      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
